prefix_adder_arbiter: RTL and testbench
=======================================

# prefix_adder_arbiter

Shares a single `prefix_adder` datapath between `nreq` independent requesters. It accepts at most one addition per cycle using round-robin arbitration, with a valid/ready handshake on each requester port. The sum, carry-out and winning requester ID are held in a one-deep output register until the consumer takes them. It sits between client blocks and the shared adder, so the adder never has more than one operand set presented to it.

## Interface
Parameters:
- `width`, 8: operand and sum width in bits, ≥1.
- `nreq`, 4: number of requesters, ≥2; need not be a power of two.
- `idw`, `$clog2(nreq)`: derived ID width, minimum 1; not overridden.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input nreq: bit i set when requester i presents an operand set.
- `req_ready` output nreq: bit i set when requester i's operand set is accepted this cycle.
- `req_cin` input nreq: carry-in per requester.
- `req_a` input nreq*width: requester i's operand A at bits [i*width +: width].
- `req_b` input nreq*width: requester i's operand B, same packing.
- `rsp_valid` output 1: output register holds a result.
- `rsp_ready` input 1: consumer accepts the held result.
- `rsp_id` output idw: index of the requester that owns the result.
- `rsp_s` output width: sum.
- `rsp_cout` output 1: carry-out.

## Operation
- State: output register is EMPTY (`rsp_valid`=0) or FULL (`rsp_valid`=1).
- Accept enable: `en = !rsp_valid || rsp_ready`.
- Winner: first index i with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping from nreq-1 to 0.
- `req_ready[i] = en && any_valid && (winner==i)`.
  - At most one bit is ever set.
  - `req_ready` may depend on `req_valid`; no output depends combinationally on `rsp_ready` except `req_ready`.
- Adder inputs are muxed from the winner's `cin`, `a` and `b`. Result is `{cout,s} = a + b + cin` mod 2^(width+1).
- On accept, the output register loads winner, s and cout; `rsp_valid`←1; `rr_ptr`←(winner+1) mod nreq.
- Drain without accept (FULL, `rsp_ready`=1, no `req_valid`): `rsp_valid`←0 and data fields keep their last value.
- Simultaneous drain and accept (FULL, `rsp_ready`=1, a request pending): new result loads and `rsp_valid` stays 1. Back-to-back throughput is 1 per cycle.
- FULL with `rsp_ready`=0: all `req_ready`=0, and the output register and `rr_ptr` hold.
- `rr_ptr` advances only on accept; an idle cycle does not move it.
- Requester rule: once `req_valid[i]` is asserted it holds, with stable operands, until `req_ready[i]`. Behaviour on violation is undefined, but the block must not lock up.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0, `rr_ptr`=0.
- Reset mid-operation discards any held result; `req_ready` is 0 while `rst_n`=0.

## Timing
- Latency is 1 cycle: operands accepted at edge N appear on `rsp_*` after edge N with `rsp_valid`=1.
- Combinational path: `req_valid` → picker → adder → output register. The `prefix_adder` is purely combinational inside that cycle.
- Fairness: with all requesters continuously valid and `rsp_ready`=1, grants cycle 0,1,…,nreq-1,0.
- A requester waits at most nreq-1 grants before being served.
- Reset assertion clears the registers immediately; deassertion is synchronised externally. The first accept can occur on the first edge after release.

## Structure
- Shared package/header `prefix_adder_pkg`:
  - EMPTY/FULL encoding.
  - clog2 helper used to derive `idw`.
  - Packing macro for the `i*width` slices.
- Sub-module `rr_priority_picker` (parameter nreq):
  - inputs: `req` vector, `ptr`.
  - outputs: one-hot `grant`, encoded `idx`, `any`.
  - purely combinational, implemented as a double-width rotate-and-priority scheme.
- The existing `prefix_adder` is instantiated once as the datapath.
- Top level holds the operand mux, output register, `rr_ptr` and handshake logic.

## Test plan
- **Reset:** assert `rst_n`=0 mid-hold with `rsp_valid`=1 → all `rsp_*`=0 and `req_ready`=0 immediately. After release, the first grant goes to requester 0.
- **Single request:** width=8, requester 2 sends a=0xFF, b=0x01, cin=1 with `rsp_ready`=1 → next cycle `rsp_s`=0x01, `rsp_cout`=1, `rsp_id`=2. Then `rr_ptr`=3.
- **Round-robin:** nreq=4, all valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1, one result per cycle.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with requesters 1 and 3 valid → `req_ready`=0 throughout and `rsp_*` stable. Raising `rsp_ready` → the next ID follows `rr_ptr`, with no lost or duplicated result.
- **Non-power-of-two wrap:** nreq=3 with `rr_ptr`=2 and only requester 0 valid → requester 0 is granted and `rr_ptr`←1.
- **Drain/accept overlap and drain-only:**
  - FULL, `rsp_ready`=1, new request a=0x80, b=0x80, cin=0 → `rsp_valid` stays 1, `rsp_s`=0x00, `rsp_cout`=1.
  - Next cycle, no request → `rsp_valid`=0.

Source files
------------

// File: rtl/prefix_adder_pkg.sv
// rtl/prefix_adder_pkg.sv - shared types, id-width helper and operand slice macro
package prefix_adder_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  // Ceil-log2 that never returns less than 1, so a requester index always has a bit.
  function automatic int id_width(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`define PA_SLICE(i, w) (i)*(w) +: (w)

// File: rtl/prefix_adder.sv
// rtl/prefix_adder.sv - combinational Kogge-Stone adder, {cout,s} = a + b + cin
module prefix_adder #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] s,
  output logic             cout
);

  localparam int levels = (width > 1) ? $clog2(width) : 0;

  logic [width-1:0] hp, g, p, gn, pn, c;

  always_comb begin
    hp = a ^ b;
    g  = a & b;
    // Fold carry-in into bit 0 so every prefix G[i] is the carry out of bit i.
    g[0] = g[0] | (hp[0] & cin);
    p  = hp;
    gn = g;
    pn = p;
    for (int l = 0; l < levels; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < width; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < width; i++) c[i] = g[i-1];
    s    = hp ^ c;
    cout = g[width-1];
  end

endmodule

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin picker using a doubled request vector
module rr_priority_picker import prefix_adder_pkg::*; #(
  parameter int nreq = 4,
  parameter int idw  = id_width(nreq)
) (
  input  logic [nreq-1:0] req,
  input  logic [idw-1:0]  ptr,
  output logic [nreq-1:0] grant,
  output logic [idw-1:0]  idx,
  output logic            any
);

  logic [2*nreq-1:0] dbl;
  logic [nreq-1:0]   rot;
  logic [idw-1:0]    off;
  logic [idw:0]      sum;

  always_comb begin
    dbl = {req, req};
    rot = nreq'(dbl >> ptr);
    any = |req;
    off = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      if (rot[i]) off = idw'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (idw+1)'(nreq)) sum = sum - (idw+1)'(nreq);
    idx   = sum[idw-1:0];
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/prefix_adder_arbiter.sv
// rtl/prefix_adder_arbiter.sv - round-robin sharing of one prefix adder with a one-deep result register
module prefix_adder_arbiter import prefix_adder_pkg::*; #(
  parameter int  width = 8,
  parameter int  nreq  = 4,
  localparam int idw   = id_width(nreq)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [nreq-1:0]       req_valid,
  output logic [nreq-1:0]       req_ready,
  input  logic [nreq-1:0]       req_cin,
  input  logic [nreq*width-1:0] req_a,
  input  logic [nreq*width-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [idw-1:0]        rsp_id,
  output logic [width-1:0]      rsp_s,
  output logic                  rsp_cout
);

  ostate_t          state;
  logic [idw-1:0]   rr_ptr, win;
  logic [nreq-1:0]  grant;
  logic             any, accept, op_cin, cout;
  logic [width-1:0] op_a, op_b, sum;

  rr_priority_picker #(.nreq(nreq)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  // Gated by rst_n so no requester sees a handshake while held in reset.
  assign accept    = rst_n && any && ((state == EMPTY) || rsp_ready);
  assign req_ready = accept ? grant : '0;
  assign rsp_valid = (state == FULL);

  assign op_a   = req_a[`PA_SLICE(win, width)];
  assign op_b   = req_b[`PA_SLICE(win, width)];
  assign op_cin = req_cin[win];

  prefix_adder #(.width(width)) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
    end else if (accept) begin
      state    <= FULL;
      rsp_id   <= win;
      rsp_s    <= sum;
      rsp_cout <= cout;
      rr_ptr   <= (win == idw'(nreq - 1)) ? '0 : win + 1'b1;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// tb/tb_prefix_adder_arbiter.sv - directed and randomized bench with a behavioural reference model
module tb_prefix_adder_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_cin;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_s;

  logic [2:0]     v3, rdy3, cin3;
  logic [3*W-1:0] a3, b3;
  logic           rsp_valid3, rsp_ready3, rsp_cout3;
  logic [1:0]     rsp_id3;
  logic [W-1:0]   rsp_s3;

  always #5 clk = ~clk;

  prefix_adder_arbiter #(.width(W), .nreq(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout)
  );

  prefix_adder_arbiter #(.width(W), .nreq(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(rdy3), .req_cin(cin3),
    .req_a(a3), .req_b(b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_s(rsp_s3), .rsp_cout(rsp_cout3)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: held result, its validity and the round-robin pointer.
  int m_ptr, m_id, m_s, m_cout, last_g;
  bit m_valid;
  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_s = 0; m_cout = 0; m_valid = 0; last_g = -1;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    int sum;
    logic [N-1:0] exp_rdy;
    #1;
    g = (!m_valid || rsp_ready) ? pick(req_valid, m_ptr) : -1;
    exp_rdy = '0;
    sum = 0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      sum = req_a[g*W +: W] + req_b[g*W +: W] + req_cin[g];
    end
    chk("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_s     = sum & 'hFF;
      m_cout  = (sum >> W) & 1;
      m_ptr   = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    last_g = g;
    #1;
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_s", rsp_s, m_s);
    chk("rsp_cout", rsp_cout, m_cout);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_cin = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    v3 = '0; cin3 = '0; a3 = '0; b3 = '0; rsp_ready3 = 1'b1;
    model_reset();

    // Reset state
    #2;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_id", rsp_id, 0);
    chk("reset_s", rsp_s, 0);
    chk("reset_cout", rsp_cout, 0);
    req_valid = '1;
    #1;
    chk("reset_ready", req_ready, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with every requester valid
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'($urandom);
      req_b[i*W +: W] = 8'($urandom);
      req_cin[i] = 1'($urandom);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_seq", rsp_id, rr_exp[k]);
    end
    req_valid = '0;
    cycle();
    chk("drain_idle", rsp_valid, 0);

    // Single request from requester 2
    req_a[2*W +: W] = 8'hFF; req_b[2*W +: W] = 8'h01; req_cin[2] = 1'b1;
    req_valid = 4'b0100;
    cycle();
    chk("single_s", rsp_s, 8'h01);
    chk("single_cout", rsp_cout, 1);
    chk("single_id", rsp_id, 2);
    req_valid = '0;

    // Backpressure with requesters 1 and 3 waiting, then release
    rsp_ready = 1'b0;
    req_a[1*W +: W] = 8'($urandom); req_b[1*W +: W] = 8'($urandom); req_cin[1] = 1'($urandom);
    req_a[3*W +: W] = 8'($urandom); req_b[3*W +: W] = 8'($urandom); req_cin[3] = 1'($urandom);
    req_valid = 4'b1010;
    repeat (5) cycle();
    rsp_ready = 1'b1;
    cycle();
    chk("bp_first_id", rsp_id, 3);
    req_valid = 4'b0010;
    cycle();
    chk("bp_second_id", rsp_id, 1);
    req_valid = '0;
    cycle();

    // Drain/accept overlap, then drain only
    req_a[0 +: W] = 8'($urandom); req_b[0 +: W] = 8'($urandom); req_cin[0] = 1'($urandom);
    req_valid = 4'b0001;
    cycle();
    req_a[1*W +: W] = 8'h80; req_b[1*W +: W] = 8'h80; req_cin[1] = 1'b0;
    req_valid = 4'b0010;
    cycle();
    chk("overlap_valid", rsp_valid, 1);
    chk("overlap_s", rsp_s, 8'h00);
    chk("overlap_cout", rsp_cout, 1);
    req_valid = '0;
    cycle();
    chk("drain_only_valid", rsp_valid, 0);

    // Randomized traffic obeying the hold-until-ready rule
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_g == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_a[i*W +: W] = 8'($urandom);
          req_b[i*W +: W] = 8'($urandom);
          req_cin[i] = 1'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;

    // Three-requester instance: wrap from pointer 2 back to requester 0
    v3 = 3'b010;
    a3 = {8'h00, 8'h11, 8'hF0};
    b3 = {8'h00, 8'h22, 8'h0F};
    cin3 = 3'b001;
    #1;
    chk("n3_rdy_a", rdy3, 3'b010);
    @(posedge clk);
    #1;
    chk("n3_id_a", rsp_id3, 1);
    chk("n3_s_a", rsp_s3, 8'h33);
    v3 = 3'b001;
    #1;
    chk("n3_rdy_wrap", rdy3, 3'b001);
    @(posedge clk);
    #1;
    chk("n3_id_wrap", rsp_id3, 0);
    chk("n3_s_wrap", rsp_s3, 8'h00);
    chk("n3_cout_wrap", rsp_cout3, 1);
    v3 = 3'b111;
    #1;
    chk("n3_rdy_ptr1", rdy3, 3'b010);
    @(posedge clk);
    #1;
    chk("n3_id_ptr1", rsp_id3, 1);
    v3 = '0;
    m_valid = 0;

    // Reset while a result is held under backpressure
    req_a[3*W +: W] = 8'h12; req_b[3*W +: W] = 8'h34; req_cin[3] = 1'b0;
    req_valid = 4'b1000;
    cycle();
    req_valid = '1;
    rsp_ready = 1'b0;
    cycle();
    chk("held_s", rsp_s, 8'h46);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", rsp_valid, 0);
    chk("midreset_id", rsp_id, 0);
    chk("midreset_s", rsp_s, 0);
    chk("midreset_cout", rsp_cout, 0);
    chk("midreset_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rsp_ready = 1'b1;
    cycle();
    chk("first_after_reset", rsp_id, 0);
    req_valid = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
